// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and defaults for the UART receive control
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_CHK = 2'd1,
    RECV      = 2'd2,
    STOP_CHK  = 2'd3
  } rx_state_t;

  localparam int UART_CLKS_PER_BIT = 10;
  localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit cycle counter with clear/enable and a one-cycle wrap flag
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            clear,
  input  logic                            enable,
  output logic [$clog2(CLKS_PER_BIT)-1:0] count,
  output logic                            wrap
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  // Combinational so the caller can register it into a strobe aligned with the wrap edge.
  assign wrap = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive control: start qualify, bit timing, stop check, host status
// Optional UART_RX_SYNC_EN inserts a 2-flop synchroniser on serial_in.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic [DATA_BITS:0]   packet_data,
  input  logic                 data_read,
  output logic                 shift_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 2);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS + 1);

  rx_state_t     state;
  logic [BW-1:0] bit_cnt;
  logic          rx_s;
  logic          rx_prev;
  logic          fall;
  logic [TW-1:0] t_count;
  logic          t_wrap;
  logic          t_clear;
  logic          t_enable;
  logic          half_done;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_ff;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_ff <= 2'b11;
    end else begin
      sync_ff <= {sync_ff[0], serial_in};
    end
  end

  assign rx_s = sync_ff[1];
`else
  assign rx_s = serial_in;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_s;
    end
  end

  assign fall      = rx_prev && !rx_s;
  assign half_done = (state == START_CHK) && (t_count == HALF_LAST);
  assign t_clear   = (state == IDLE) || (state == STOP_CHK) || half_done;
  assign t_enable  = (state == START_CHK) || (state == RECV);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (t_clear),
    .enable(t_enable),
    .count (t_count),
    .wrap  (t_wrap)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift_enable  <= 1'b0;
      rx_data       <= '1;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      shift_enable <= 1'b0;
      if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (fall) begin
            state         <= START_CHK;
            framing_error <= 1'b0;
          end
        end
        START_CHK: begin
          if (half_done) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= RECV;
              bit_cnt <= '0;
            end
          end
        end
        RECV: begin
          // One cycle after the last strobe so the shift register has taken the stop bit.
          if (bit_cnt == LAST_BIT) begin
            state <= STOP_CHK;
          end else if (t_wrap) begin
            shift_enable <= 1'b1;
            bit_cnt      <= bit_cnt + 1'b1;
          end
        end
        STOP_CHK: begin
          state <= IDLE;
          if (!packet_data[DATA_BITS]) begin
            framing_error <= 1'b1;
          end else begin
            rx_data    <= packet_data[DATA_BITS-1:0];
            data_ready <= 1'b1;
            if (data_ready && !data_read) begin
              overrun_error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl with a behavioural 9-bit shift register
module tb_uart_rx_ctrl;

`ifdef UART_RX_SYNC_EN
  localparam int DET_LAT = 3;
`else
  localparam int DET_LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       n_rst;
  logic       serial_in;
  logic       data_read;
  logic [8:0] packet_data;
  logic       shift_enable;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       framing_error;
  logic       overrun_error;

  typedef struct {
    int         t;
    logic [7:0] d;
    logic       r;
    logic       fe;
    logic       ov;
  } res_t;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_strobe[$];
  res_t exp_res[$];
  res_t mon_e;

  logic [7:0] m_data;
  logic       m_ready, m_fe, m_ov;

  uart_rx_ctrl #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .packet_data  (packet_data),
    .data_read    (data_read),
    .shift_enable (shift_enable),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .framing_error(framing_error),
    .overrun_error(overrun_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // flex_stp_sr, NUM_BITS=9, SHIFT_MSB=0: new bit enters at the top, stop bit ends in [8].
  always @(posedge clk) begin
    if (!n_rst) packet_data <= '1;
    else if (shift_enable) packet_data <= {serial_in, packet_data[8:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (shift_enable === 1'b1) begin
      if (exp_strobe.size() == 0) check("strobe_unexpected", {31'b0, shift_enable}, 32'd0);
      else check("strobe_time", cyc, exp_strobe.pop_front());
    end
    if (exp_res.size() > 0 && exp_res[0].t == cyc) begin
      mon_e = exp_res.pop_front();
      check("rx_data", {24'b0, rx_data}, {24'b0, mon_e.d});
      check("data_ready", {31'b0, data_ready}, {31'b0, mon_e.r});
      check("framing_error", {31'b0, framing_error}, {31'b0, mon_e.fe});
      check("overrun_error", {31'b0, overrun_error}, {31'b0, mon_e.ov});
    end
  end

  function automatic logic lvl(input int i, input logic [7:0] b, input logic stop);
    if (i < 10) return 1'b0;
    if (i < 90) return b[i/10-1];
    if (i < 100) return stop;
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd);
    int d, t0;
    @(negedge clk);
    d  = cyc;
    t0 = d + DET_LAT;
    for (int k = 1; k <= 9; k++) exp_strobe.push_back(t0 + 5 + 10 * k);
    m_fe = 1'b0;
    exp_res.push_back('{t: t0, d: m_data, r: m_ready, fe: 1'b0, ov: m_ov});
    if (stop) begin
      if (rd) m_ov = 1'b0;
      else if (m_ready) m_ov = 1'b1;
      m_ready = 1'b1;
      m_data  = b;
    end else begin
      m_fe = 1'b1;
    end
    exp_res.push_back('{t: t0 + 97, d: m_data, r: m_ready, fe: m_fe, ov: m_ov});
    for (int i = 0; i < 110; i++) begin
      if (i > 0) @(negedge clk);
      serial_in = lvl(i, b, stop);
      data_read = rd && (cyc == t0 + 96);
    end
    data_read = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic read_pulse();
    @(negedge clk);
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    m_ready = 1'b0;
    m_ov    = 1'b0;
    check("read_clears_ready", {31'b0, data_ready}, 32'd0);
    check("read_clears_overrun", {31'b0, overrun_error}, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_data"}, {24'b0, rx_data}, 32'hFF);
    check({tag, "_ready"}, {31'b0, data_ready}, 32'd0);
    check({tag, "_fe"}, {31'b0, framing_error}, 32'd0);
    check({tag, "_ov"}, {31'b0, overrun_error}, 32'd0);
    check({tag, "_shift"}, {31'b0, shift_enable}, 32'd0);
  endtask

  task automatic model_reset();
    m_data  = 8'hFF;
    m_ready = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
  endtask

  initial begin
    int d, t0;
    n_rst     = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    n_rst = 1'b1;
    repeat (30) @(negedge clk);
    check_reset_values("idle");

    send_frame(8'hA5, 1'b1, 1'b0);
    read_pulse();

    @(negedge clk);
    m_fe = 1'b0;
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    repeat (40) @(negedge clk);
    check("false_start_ready", {31'b0, data_ready}, {31'b0, m_ready});
    check("false_start_fe", {31'b0, framing_error}, 32'd0);
    check("false_start_ov", {31'b0, overrun_error}, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0);

    send_frame(8'h55, 1'b0, 1'b0);
    read_pulse();

    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    read_pulse();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    read_pulse();

    @(negedge clk);
    d  = cyc;
    t0 = d + DET_LAT;
    for (int k = 1; k <= 4; k++) exp_strobe.push_back(t0 + 5 + 10 * k);
    serial_in = 1'b0;
    while (cyc < t0 + 45) begin
      @(negedge clk);
      serial_in = lvl(cyc - d, 8'h99, 1'b1);
    end
    n_rst     = 1'b0;
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("midframe_reset");
    model_reset();
    n_rst = 1'b1;
    repeat (30) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1'b0);

    repeat (20) @(negedge clk);
    check("strobe_queue_drained", exp_strobe.size(), 32'd0);
    check("result_queue_drained", exp_res.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
